// File: rtl/cordic_bist_ctrl_if.sv
// Control/status bundle between the chip-level BIST config side and the
// CORDIC BIST sequencer. The slave modport is the sequencer; the master
// modport is whoever issues start/abort and supplies the signature path.
interface cordic_bist_ctrl_if #(
  parameter int SIG_WIDTH = 54,
  parameter int CNT_WIDTH = 32
);
  logic                 i_start;
  logic                 i_abort;
  logic [CNT_WIDTH-1:0] i_max_cycles;
  logic [SIG_WIDTH-1:0] i_golden_sig;
  logic                 i_stop_hit;
  logic                 i_sig_vld;
  logic [SIG_WIDTH-1:0] i_sig_data;

  logic                 o_en;
  logic [1:0]           o_mode;
  logic [2:0]           o_bypass;
  logic                 o_seed_vld;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_pass;
  logic                 o_timeout;
  logic [CNT_WIDTH-1:0] o_run_cycles;

  modport master (
    output i_start, i_abort, i_max_cycles, i_golden_sig,
           i_stop_hit, i_sig_vld, i_sig_data,
    input  o_en, o_mode, o_bypass, o_seed_vld, o_busy,
           o_done, o_pass, o_timeout, o_run_cycles
  );

  modport slave (
    input  i_start, i_abort, i_max_cycles, i_golden_sig,
           i_stop_hit, i_sig_vld, i_sig_data,
    output o_en, o_mode, o_bypass, o_seed_vld, o_busy,
           o_done, o_pass, o_timeout, o_run_cycles
  );
endinterface

// File: rtl/cordic_bist_ctrl.sv
// CORDIC BIST sequencer: seed -> LFSR run -> pipeline drain -> signature
// check, reporting pass/fail/timeout. All outputs are registered and are
// decoded from the next state so they line up with the state register.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | waiting for start, wrapper disabled
//  SEED     | one-cycle seed-load strobe, flags cleared
//  RUN      | LFSR stimulus running, run-cycle counter advancing
//  DRAIN    | stop code seen, flushing the CORDIC pipeline
//  CHECK    | waiting for the signature analyzer result
//  DONE     | result held, wrapper disabled, mode kept at 11
module cordic_bist_ctrl #(
  parameter int SIG_WIDTH    = 54,
  parameter int CNT_WIDTH    = 32,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  cordic_bist_ctrl_if.slave   bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SEED  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [DW-1:0]        drain_cnt;
  logic [DW-1:0]        drain_cnt_nxt;
  logic                 pass_nxt;
  logic                 timeout_nxt;
  logic [CNT_WIDTH-1:0] run_cycles_nxt;

  logic [CNT_WIDTH:0]   run_inc;
  logic [CNT_WIDTH-1:0] run_sat;
  logic                 timeout_hit;
  logic                 busy_nxt;

  // One extra bit on the increment gives both the saturation carry and a
  // compare that can never alias once the counter has pinned at all-ones.
  assign run_inc     = {1'b0, bus.o_run_cycles} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign run_sat     = run_inc[CNT_WIDTH] ? bus.o_run_cycles : run_inc[CNT_WIDTH-1:0];
  assign timeout_hit = (bus.i_max_cycles != '0) && (run_inc == {1'b0, bus.i_max_cycles});

  // Next-state, drain down-counter and result-flag update.
  always_comb begin
    state_nxt      = state;
    drain_cnt_nxt  = drain_cnt;
    pass_nxt       = bus.o_pass;
    timeout_nxt    = bus.o_timeout;
    run_cycles_nxt = bus.o_run_cycles;

    if (bus.i_abort) begin
      state_nxt      = ST_IDLE;
      pass_nxt       = 1'b0;
      timeout_nxt    = 1'b0;
      run_cycles_nxt = '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            state_nxt      = ST_SEED;
            pass_nxt       = 1'b0;
            timeout_nxt    = 1'b0;
            run_cycles_nxt = '0;
          end
        end
        ST_SEED: begin
          state_nxt = ST_RUN;
        end
        ST_RUN: begin
          run_cycles_nxt = run_sat;
          // The stop code wins a same-cycle collision with the timeout.
          if (bus.i_stop_hit) begin
            state_nxt     = ST_DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
          end else if (timeout_hit) begin
            state_nxt   = ST_DONE;
            timeout_nxt = 1'b1;
            pass_nxt    = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state_nxt = ST_CHECK;
          end else begin
            drain_cnt_nxt = drain_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          // No timeout here: a hung analyzer is recovered by abort or reset.
          if (bus.i_sig_vld) begin
            state_nxt = ST_DONE;
            pass_nxt  = (bus.i_sig_data == bus.i_golden_sig);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign busy_nxt = (state_nxt == ST_SEED)  || (state_nxt == ST_RUN) ||
                    (state_nxt == ST_DRAIN) || (state_nxt == ST_CHECK);

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      drain_cnt        <= '0;
      bus.o_en         <= 1'b0;
      bus.o_mode       <= 2'b00;
      bus.o_bypass     <= 3'b000;
      bus.o_seed_vld   <= 1'b0;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_pass       <= 1'b0;
      bus.o_timeout    <= 1'b0;
      bus.o_run_cycles <= '0;
    end else begin
      state            <= state_nxt;
      drain_cnt        <= drain_cnt_nxt;
      bus.o_en         <= busy_nxt;
      bus.o_mode       <= (state_nxt == ST_IDLE) ? 2'b00 : 2'b11;
      bus.o_bypass     <= 3'b000;
      bus.o_seed_vld   <= (state_nxt == ST_SEED);
      bus.o_busy       <= busy_nxt;
      bus.o_done       <= (state_nxt == ST_DONE);
      bus.o_pass       <= pass_nxt;
      bus.o_timeout    <= timeout_nxt;
      bus.o_run_cycles <= run_cycles_nxt;
    end
  end

endmodule

// File: tb/tb_cordic_bist_ctrl.sv
// Bench for cordic_bist_ctrl: directed runs push their expected result into
// a queue; a negedge monitor pops and compares on each rising o_done.
module tb_cordic_bist_ctrl;

  localparam int SW    = 54;
  localparam int CW    = 32;
  localparam int DRAIN = 16;

  typedef struct packed {
    logic          pass;
    logic          timeout;
    logic [CW-1:0] run;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   done_seen = 0;
  exp_t exp_q[$];
  logic prev_done = 1'b0;
  logic prev_seed = 1'b0;

  cordic_bist_ctrl_if #(.SIG_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

  cordic_bist_ctrl #(.SIG_WIDTH(SW), .CNT_WIDTH(CW), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic p, input logic t, input logic [CW-1:0] r);
    exp_t e;
    e.pass = p;
    e.timeout = t;
    e.run = r;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_en"},       64'(bus.o_en), 64'd0);
    chk({tag, "_mode"},     64'(bus.o_mode), 64'd0);
    chk({tag, "_bypass"},   64'(bus.o_bypass), 64'd0);
    chk({tag, "_seed"},     64'(bus.o_seed_vld), 64'd0);
    chk({tag, "_busy"},     64'(bus.o_busy), 64'd0);
    chk({tag, "_done"},     64'(bus.o_done), 64'd0);
    chk({tag, "_pass"},     64'(bus.o_pass), 64'd0);
    chk({tag, "_timeout"},  64'(bus.o_timeout), 64'd0);
    chk({tag, "_run"},      64'(bus.o_run_cycles), 64'd0);
  endtask

  // Pulse start; afterwards the bench sits in RUN cycle 1.
  task automatic start_bist(input string tag);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk({tag, "_seed_t1"}, 64'(bus.o_seed_vld), 64'd1);
    chk({tag, "_busy_t1"}, 64'(bus.o_busy), 64'd1);
    chk({tag, "_pass_clr"}, 64'(bus.o_pass), 64'd0);
    tick();
    chk({tag, "_seed_t2"}, 64'(bus.o_seed_vld), 64'd0);
    chk({tag, "_en_run"}, 64'(bus.o_en), 64'd1);
  endtask

  // From RUN cycle 1: stop on RUN cycle stop_at, drain, then deliver sig on
  // the first CHECK cycle. A bogus result on the last DRAIN cycle must be ignored.
  task automatic stop_and_check(input string tag, input int stop_at, input logic [SW-1:0] sig);
    repeat (stop_at - 1) tick();
    bus.i_stop_hit = 1'b1;
    tick();
    bus.i_stop_hit = 1'b0;
    chk({tag, "_drain_not_done"}, 64'(bus.o_done), 64'd0);
    repeat (DRAIN - 1) tick();
    bus.i_sig_vld  = 1'b1;
    bus.i_sig_data = ~bus.i_golden_sig;
    tick();
    chk({tag, "_check_not_done"}, 64'(bus.o_done), 64'd0);
    bus.i_sig_data = sig;
    tick();
    bus.i_sig_vld = 1'b0;
    chk({tag, "_done"}, 64'(bus.o_done), 64'd1);
    chk({tag, "_en_done"}, 64'(bus.o_en), 64'd0);
    chk({tag, "_mode_done"}, 64'(bus.o_mode), 64'd3);
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_done && !prev_done) begin
        done_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("sb_pass",    64'(bus.o_pass), 64'(e.pass));
          chk("sb_timeout", 64'(bus.o_timeout), 64'(e.timeout));
          chk("sb_run",     64'(bus.o_run_cycles), 64'(e.run));
        end
      end
      if (bus.o_seed_vld) begin
        chk("seed_single", 64'(prev_seed), 64'd0);
        chk("seed_mode",   64'(bus.o_mode), 64'd3);
        chk("seed_bypass", 64'(bus.o_bypass), 64'd0);
      end
      prev_done = bus.o_done;
      prev_seed = bus.o_seed_vld;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.i_start      = 1'b0;
    bus.i_abort      = 1'b0;
    bus.i_max_cycles = '0;
    bus.i_golden_sig = 54'h1234;
    bus.i_stop_hit   = 1'b0;
    bus.i_sig_vld    = 1'b0;
    bus.i_sig_data   = '0;
    repeat (3) tick();
    check_idle("por");
    rst = 1'b0;
    tick();
    check_idle("idle");

    // Reset while in RUN: outputs drop on the first reset edge.
    start_bist("rst");
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rst_en_same_edge", 64'(bus.o_en), 64'd0);
    repeat (2) tick();
    check_idle("rst");
    rst = 1'b0;
    tick();

    // Pass run.
    push_exp(1'b1, 1'b0, 32'd100);
    start_bist("pass");
    stop_and_check("pass", 100, 54'h1234);
    tick();

    // Fail run, started straight from DONE.
    push_exp(1'b0, 1'b0, 32'd100);
    start_bist("fail");
    stop_and_check("fail", 100, 54'h1235);
    tick();

    // Timeout after 50 RUN cycles; a start pulse while busy is ignored.
    bus.i_max_cycles = 32'd50;
    push_exp(1'b0, 1'b1, 32'd50);
    start_bist("tmo");
    for (int i = 1; i <= 49; i++) begin
      if (i == 5) bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      if (i == 5) chk("tmo_start_ignored", 64'(bus.o_seed_vld), 64'd0);
    end
    chk("tmo_not_yet", 64'(bus.o_done), 64'd0);
    tick();
    chk("tmo_done", 64'(bus.o_done), 64'd1);
    tick();

    // Stop hit on the same RUN cycle that would time out.
    bus.i_max_cycles = 32'd10;
    push_exp(1'b1, 1'b0, 32'd10);
    start_bist("col");
    stop_and_check("col", 10, 54'h1234);
    tick();

    // Abort during DRAIN, then a full pass run.
    bus.i_max_cycles = '0;
    start_bist("abt");
    repeat (4) tick();
    bus.i_stop_hit = 1'b1;
    tick();
    bus.i_stop_hit = 1'b0;
    repeat (2) tick();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("abt_en",      64'(bus.o_en), 64'd0);
    chk("abt_mode",    64'(bus.o_mode), 64'd0);
    chk("abt_busy",    64'(bus.o_busy), 64'd0);
    chk("abt_done",    64'(bus.o_done), 64'd0);
    chk("abt_pass",    64'(bus.o_pass), 64'd0);
    chk("abt_timeout", 64'(bus.o_timeout), 64'd0);
    repeat (20) tick();
    chk("abt_stays_idle", 64'(bus.o_busy), 64'd0);
    push_exp(1'b1, 1'b0, 32'd20);
    start_bist("rst2");
    stop_and_check("rst2", 20, 54'h1234);

    repeat (5) tick();
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("sb_done_count",  64'(done_seen), 64'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
